// File: rtl/linebuf_pkg.sv
// Shared state type and elaboration helpers for the line-buffer scheduler.
// Build option LBS_WR_PRIORITY_EN (used in rr_arb2) selects fixed writer priority.
package linebuf_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } lbs_state_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

    function automatic bit addr_fits(input int lines, input int img_w, input int addr_w);
        return (lines * img_w) <= (32'sd1 <<< addr_w);
    endfunction

endpackage

// File: rtl/linebuf_sched_if.sv
// Request/grant handshake and BRAM-port bundle of the line-buffer scheduler.
// slave: the scheduler; master: the writer/reader/BRAM side.
interface linebuf_sched_if #(
    parameter int ADDR_W = 11
);
    logic              wr_req;
    logic              wr_gnt;
    logic              rd_req;
    logic              rd_gnt;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [2:0]        rd_row;
    logic              win_ready;
    logic              frame_done;

    modport master (
        output wr_req, rd_req,
        input  wr_gnt, rd_gnt, bram_addr, bram_en, bram_we, rd_row, win_ready, frame_done
    );

    modport slave (
        input  wr_req, rd_req,
        output wr_gnt, rd_gnt, bram_addr, bram_en, bram_we, rd_row, win_ready, frame_done
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester arbiter; the loser of the last contended cycle wins the next one.
// With LBS_WR_PRIORITY_EN defined, requester 0 (writer) always wins and no pointer is kept.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);
`ifdef LBS_WR_PRIORITY_EN
    logic unused_s;
    assign unused_s = clk ^ reset;

    // Fixed priority grant
    always_comb begin
        gnt0_o = req0_i;
        gnt1_o = req1_i && !req0_i;
    end
`else
    logic prio_q, prio_d;   // 1: requester 1 wins the next contention

    // Grant and pointer update
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        prio_d = prio_q;
        if (req0_i && req1_i) begin
            if (prio_q) begin
                gnt1_o = 1'b1;
                prio_d = 1'b0;
            end else begin
                gnt0_o = 1'b1;
                prio_d = 1'b1;
            end
        end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif
endmodule

// File: rtl/linebuf_sched.sv
// Line-buffer BRAM port scheduler: grants writer/reader, generates addresses, tracks resident lines.
// Build option LBS_WR_PRIORITY_EN: writer wins every contention (see rr_arb2).
module linebuf_sched
    import linebuf_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int LINES  = 4,
    parameter int WIN    = 3,
    parameter int ADDR_W = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    linebuf_sched_if.slave bus
);
    localparam int COL_W  = cnt_w(IMG_W);
    localparam int SLOT_W = cnt_w(LINES);
    localparam int LINE_W = cnt_w(IMG_H + 1);
    localparam int HELD_W = cnt_w(LINES + 1);
    localparam int ROW_W  = cnt_w(WIN);
    localparam bit STRIDE_POW2 = is_pow2(IMG_W);

    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(LINES - 1);
    localparam logic [SLOT_W:0]   SUM_LINES   = (SLOT_W + 1)'(LINES);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(WIN - 1);
    localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(IMG_H - 1);
    localparam logic [LINE_W-1:0] LINES_END   = LINE_W'(IMG_H);
    localparam logic [LINE_W-1:0] ROWS_END    = LINE_W'(IMG_H - WIN + 1);
    localparam logic [HELD_W-1:0] HELD_MAX    = HELD_W'(LINES);
    localparam logic [HELD_W-1:0] HELD_WIN    = HELD_W'(WIN);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(IMG_W);

    lbs_state_e        state_q, state_d;
    logic [COL_W-1:0]  wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d, rd_base_q, rd_base_d;
    logic [LINE_W-1:0] wr_line_q, wr_line_d, rows_done_q, rows_done_d;
    logic [HELD_W-1:0] held_q, held_d;
    logic [ROW_W-1:0]  rd_r_q, rd_r_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic              bram_en_q, bram_en_d, bram_we_q, bram_we_d;
    logic [2:0]        rd_row_q, rd_row_d;

    logic              wr_elig_s, rd_elig_s, wr_gnt_s, rd_gnt_s;
    logic              wr_line_done_s, rd_row_done_s;
    logic [SLOT_W:0]   rd_sum_s;
    logic [SLOT_W-1:0] rd_slot_s;

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] slot);
        return (slot == SLOT_LAST) ? {SLOT_W{1'b0}} : slot + SLOT_W'(1);
    endfunction

    // Power-of-two line length turns slot*IMG_W into a shift
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] slot,
                                                    input logic [COL_W-1:0]  col);
        if (STRIDE_POW2) begin
            return (ADDR_W'(slot) << COL_W) | ADDR_W'(col);
        end else begin
            return ADDR_W'(slot) * LINE_STRIDE + ADDR_W'(col);
        end
    endfunction

    // Requester eligibility and ring slot of the current window row
    always_comb begin
        wr_elig_s = ((state_q == FILL) || (state_q == RUN)) &&
                    (held_q < HELD_MAX) && (wr_line_q < LINES_END);
        rd_elig_s = ((state_q == RUN) || (state_q == DRAIN)) &&
                    (held_q >= HELD_WIN) && (rows_done_q < ROWS_END);
        rd_sum_s  = (SLOT_W + 1)'(rd_base_q) + (SLOT_W + 1)'(rd_r_q);
        if (rd_sum_s >= SUM_LINES) begin
            rd_slot_s = SLOT_W'(rd_sum_s - SUM_LINES);
        end else begin
            rd_slot_s = SLOT_W'(rd_sum_s);
        end
    end

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0_i (bus.wr_req && wr_elig_s && en && !reset),
        .req1_i (bus.rd_req && rd_elig_s && en && !reset),
        .gnt0_o (wr_gnt_s),
        .gnt1_o (rd_gnt_s)
    );

    // Next state of the frame FSM, ring counters and BRAM-port registers
    always_comb begin
        state_d     = state_q;
        wr_col_d    = wr_col_q;
        wr_slot_d   = wr_slot_q;
        wr_line_d   = wr_line_q;
        rd_col_d    = rd_col_q;
        rd_r_d      = rd_r_q;
        rd_base_d   = rd_base_q;
        rows_done_d = rows_done_q;
        held_d      = held_q;
        bram_addr_d = bram_addr_q;
        bram_en_d   = 1'b0;
        bram_we_d   = bram_we_q;
        rd_row_d    = rd_row_q;
        wr_line_done_s = wr_gnt_s && (wr_col_q == COL_LAST);
        rd_row_done_s  = rd_gnt_s && (rd_r_q == ROW_LAST) && (rd_col_q == COL_LAST);

        if (en) begin
            bram_en_d = wr_gnt_s || rd_gnt_s;
            bram_we_d = wr_gnt_s;
            if (wr_gnt_s) begin
                bram_addr_d = slot_addr(wr_slot_q, wr_col_q);
                if (wr_col_q == COL_LAST) begin
                    wr_col_d  = {COL_W{1'b0}};
                    wr_slot_d = slot_inc(wr_slot_q);
                    wr_line_d = wr_line_q + LINE_W'(1);
                end else begin
                    wr_col_d = wr_col_q + COL_W'(1);
                end
            end else if (rd_gnt_s) begin
                bram_addr_d = slot_addr(rd_slot_s, rd_col_q);
                rd_row_d    = 3'(rd_r_q);
                if (rd_r_q != ROW_LAST) begin
                    rd_r_d = rd_r_q + ROW_W'(1);
                end else if (rd_col_q != COL_LAST) begin
                    rd_r_d   = {ROW_W{1'b0}};
                    rd_col_d = rd_col_q + COL_W'(1);
                end else begin
                    rd_r_d      = {ROW_W{1'b0}};
                    rd_col_d    = {COL_W{1'b0}};
                    rd_base_d   = slot_inc(rd_base_q);
                    rows_done_d = rows_done_q + LINE_W'(1);
                end
            end else begin
                bram_addr_d = bram_addr_q;
            end

            case ({wr_line_done_s, rd_row_done_s})
                2'b10:   held_d = held_q + HELD_W'(1);
                2'b01:   held_d = held_q - HELD_W'(1);
                default: held_d = held_q;
            endcase

            // Run starts as soon as the completing write makes a window resident
            case (state_q)
                IDLE:  state_d = FILL;
                FILL:  state_d = (held_d >= HELD_WIN) ? RUN : FILL;
                RUN:   state_d = (wr_line_done_s && (wr_line_q == LINE_LAST)) ? DRAIN : RUN;
                DRAIN: state_d = (rows_done_q == ROWS_END) ? DONE : DRAIN;
                DONE: begin
                    state_d     = FILL;
                    wr_col_d    = {COL_W{1'b0}};
                    wr_slot_d   = {SLOT_W{1'b0}};
                    wr_line_d   = {LINE_W{1'b0}};
                    rd_col_d    = {COL_W{1'b0}};
                    rd_r_d      = {ROW_W{1'b0}};
                    rd_base_d   = {SLOT_W{1'b0}};
                    rows_done_d = {LINE_W{1'b0}};
                    held_d      = {HELD_W{1'b0}};
                end
                default: state_d = IDLE;
            endcase
        end else begin
            bram_en_d = 1'b0;
        end
    end

    // FSM state, counters and registered BRAM-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_col_q    <= {COL_W{1'b0}};
            wr_slot_q   <= {SLOT_W{1'b0}};
            wr_line_q   <= {LINE_W{1'b0}};
            rd_col_q    <= {COL_W{1'b0}};
            rd_r_q      <= {ROW_W{1'b0}};
            rd_base_q   <= {SLOT_W{1'b0}};
            rows_done_q <= {LINE_W{1'b0}};
            held_q      <= {HELD_W{1'b0}};
            bram_addr_q <= {ADDR_W{1'b0}};
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            rd_row_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            wr_col_q    <= wr_col_d;
            wr_slot_q   <= wr_slot_d;
            wr_line_q   <= wr_line_d;
            rd_col_q    <= rd_col_d;
            rd_r_q      <= rd_r_d;
            rd_base_q   <= rd_base_d;
            rows_done_q <= rows_done_d;
            held_q      <= held_d;
            bram_addr_q <= bram_addr_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            rd_row_q    <= rd_row_d;
        end
    end

    assign bus.wr_gnt     = wr_gnt_s;
    assign bus.rd_gnt     = rd_gnt_s;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_en    = bram_en_q;
    assign bus.bram_we    = bram_we_q;
    assign bus.rd_row     = rd_row_q;
    assign bus.win_ready  = rd_elig_s;
    assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_linebuf_sched.sv
// Directed bench for linebuf_sched (8x6 image, 4 slots, 3-line window): fill, read order,
// ring wrap, contention, frame end and mid-frame reset. Honours LBS_WR_PRIORITY_EN.
module tb_linebuf_sched;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int LINES  = 4;
    localparam int WIN    = 3;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic g_w, g_r;
    int   n_assert = 0;
    int   n_fail   = 0;

    linebuf_sched_if #(.ADDR_W(ADDR_W)) bus ();

    linebuf_sched #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .LINES  (LINES),
        .WIN    (WIN),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive requests, sample combinational grants, then step past the edge
    task automatic cyc(input logic w, input logic r);
        bus.wr_req = w;
        bus.rd_req = r;
        #1;
        g_w = bus.wr_gnt;
        g_r = bus.rd_gnt;
        @(posedge clk);
        #1;
    endtask

    // Window read j of row starting at ring slot b
    function automatic int rd_addr(input int b, input int j);
        return (((b + (j % WIN)) % LINES) * IMG_W) + (j / WIN);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  32'(bus.bram_addr),  32'd0);
        chk({tag, "_en"},    32'(bus.bram_en),    32'd0);
        chk({tag, "_we"},    32'(bus.bram_we),    32'd0);
        chk({tag, "_row"},   32'(bus.rd_row),     32'd0);
        chk({tag, "_wgnt"},  32'(bus.wr_gnt),     32'd0);
        chk({tag, "_rgnt"},  32'(bus.rd_gnt),     32'd0);
        chk({tag, "_ready"}, 32'(bus.win_ready),  32'd0);
        chk({tag, "_fdone"}, 32'(bus.frame_done), 32'd0);
    endtask

    initial begin
        int  b;
        int  j;
        int  wn;
        logic exp_w;

        reset = 1'b1;
        en = 1'b0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk_reset_outputs("rst");

        en = 1'b1;
        cyc(1'b0, 1'b0);

        // Fill: 4 lines land in slots 0..3, window becomes ready after line 2
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0);
            chk("fill_gnt",   32'(g_w),           32'd1);
            chk("fill_addr",  32'(bus.bram_addr), 32'(i));
            chk("fill_we",    32'(bus.bram_we),   32'd1);
            chk("fill_en",    32'(bus.bram_en),   32'd1);
            chk("fill_ready", 32'(bus.win_ready), 32'(i >= 23));
        end
        cyc(1'b1, 1'b0);
        chk("full_block",  32'(g_w),           32'd0);
        chk("full_en",     32'(bus.bram_en),   32'd0);
        chk("full_hold",   32'(bus.bram_addr), 32'd31);

        en = 1'b0;
        cyc(1'b0, 1'b1);
        chk("enlow_gnt",   32'(g_r),           32'd0);
        chk("enlow_en",    32'(bus.bram_en),   32'd0);
        chk("enlow_hold",  32'(bus.bram_addr), 32'd31);
        en = 1'b1;

        // Row 0 minus its last pixel; writer must stay blocked
        for (int k = 0; k < 23; k++) begin
            cyc(1'b0, 1'b1);
            chk("rd0_gnt",  32'(g_r),           32'd1);
            chk("rd0_addr", 32'(bus.bram_addr), 32'(rd_addr(0, k)));
            chk("rd0_row",  32'(bus.rd_row),    32'(k % WIN));
            chk("rd0_we",   32'(bus.bram_we),   32'd0);
        end
        cyc(1'b1, 1'b0);
        chk("wrap_block", 32'(g_w), 32'd0);
        cyc(1'b0, 1'b1);
        chk("rd0_last",   32'(bus.bram_addr), 32'd23);

        // Line 4 reuses slot 0 once row 0 is retired
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            chk("wrap_gnt",  32'(g_w),           32'd1);
            chk("wrap_addr", 32'(bus.bram_addr), 32'(i));
        end
        for (int k = 0; k < 24; k++) begin
            cyc(1'b0, 1'b1);
            chk("rd1_gnt",  32'(g_r),           32'd1);
            chk("rd1_addr", 32'(bus.bram_addr), 32'(rd_addr(1, k)));
        end

        // Contention: writer line 5 into slot 1 against reader row 2
        wn = 0;
        j = 0;
        for (int c = 0; c < 16; c++) begin
`ifdef LBS_WR_PRIORITY_EN
            exp_w = (c < 8);
`else
            exp_w = ((c % 2) == 0);
`endif
            cyc(1'b1, 1'b1);
            chk("arb_wr", 32'(g_w), 32'(exp_w));
            chk("arb_rd", 32'(g_r), 32'(!exp_w));
            if (exp_w) begin
                chk("arb_waddr", 32'(bus.bram_addr), 32'(8 + wn));
                chk("arb_we",    32'(bus.bram_we),   32'd1);
                wn++;
            end else begin
                chk("arb_raddr", 32'(bus.bram_addr), 32'(rd_addr(2, j)));
                chk("arb_rwe",   32'(bus.bram_we),   32'd0);
                j++;
            end
        end

        // Drain the rest of rows 2 and 3
        b = 2;
        for (int n = 0; n < 40; n++) begin
            cyc(1'b0, 1'b1);
            chk("drain_gnt",  32'(g_r),           32'd1);
            chk("drain_addr", 32'(bus.bram_addr), 32'(rd_addr(b, j)));
            j++;
            if (j == 24) begin
                j = 0;
                b++;
            end
        end
        chk("drain_ready", 32'(bus.win_ready),  32'd0);
        chk("drain_fdone", 32'(bus.frame_done), 32'd0);
        cyc(1'b0, 1'b1);
        chk("end_rgnt",    32'(g_r),            32'd0);
        chk("fdone_pulse", 32'(bus.frame_done), 32'd1);
        cyc(1'b1, 1'b0);
        chk("done_wgnt",   32'(g_w),            32'd0);
        chk("fdone_clear", 32'(bus.frame_done), 32'd0);

        // New frame restarts at slot 0, line 0
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 1'b0);
            chk("nf_gnt",  32'(g_w),           32'd1);
            chk("nf_addr", 32'(bus.bram_addr), 32'(i));
        end
        chk("nf_ready", 32'(bus.win_ready),  32'd1);
        chk("nf_fdone", 32'(bus.frame_done), 32'd0);

        // Reset with three lines resident
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            chk("post_rst_rgnt",  32'(g_r),           32'd0);
            chk("post_rst_ready", 32'(bus.win_ready), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/linebuf_sched.md
# linebuf_sched

Single-clock scheduler for the image line-buffer BRAM. It arbitrates one BRAM port between the pixel writer and the window (kernel) reader, and generates every BRAM address and write enable. It tracks how many complete lines are resident in the ring of line slots and gates the reader until a full window of lines is available. It sits between the pixel input stream, the line-buffer BRAM and the convolution engine, and replaces free-running read/write address counters with a request/grant handshake.

## Interface
- IMG_W, 256: pixels per line
- IMG_H, 256: lines per frame
- LINES, 4: line slots in BRAM ring; must be ≥ WIN+1
- WIN, 3: window height (lines read per column)
- ADDR_W, 11: BRAM address width; LINES*IMG_W ≤ 2**ADDR_W
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  global enable; low freezes all state, grants 0, bram_en 0
- wr_req  in  1  writer has a pixel
- wr_gnt  out  1  pixel accepted this cycle (combinational)
- rd_req  in  1  reader wants next window pixel
- rd_gnt  out  1  read accepted this cycle (combinational)
- bram_addr  out  ADDR_W  registered BRAM address
- bram_en  out  1  registered port enable
- bram_we  out  1  registered write enable
- rd_row  out  3  window row (0..WIN-1) of the registered read
- win_ready  out  1  ≥ WIN complete lines resident and rows remain
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, FILL, RUN, DRAIN, DONE. Reset → IDLE. IDLE → FILL when en=1.
- FILL → RUN when held ≥ WIN. RUN → DRAIN when the writer completes line IMG_H-1. DRAIN → DONE when rows_done = IMG_H-WIN+1. DONE → FILL after one cycle; all counters cleared.
- held (0..LINES): complete, unretired lines. +1 when the writer completes a line; -1 when the reader finishes a window row. Both in the same cycle: unchanged.
- Writer eligible: state FILL/RUN, held < LINES, wr_line < IMG_H. Address = wr_slot*IMG_W + wr_col.
- wr_col wraps IMG_W-1 → 0, then wr_slot advances mod LINES.
- Reader eligible: state RUN/DRAIN, held ≥ WIN, rows_done < IMG_H-WIN+1.
- Read address = ((rd_base + rd_r) mod LINES)*IMG_W + rd_col.
- Read order: rd_r steps 0..WIN-1 per column, then rd_col advances. At rd_col wrap: rd_base +1 mod LINES, rows_done +1, held -1.
- Arbitration: when exactly one requester is eligible and requesting, it is granted. When both are, round-robin: the loser of the last contended cycle wins. At most one grant per cycle.
- A transfer occurs when req & gnt. A requester without a grant holds req; nothing is consumed.
- win_ready = reader eligible.
- Outputs in reset: bram_addr=0, bram_en=0, bram_we=0, rd_row=0, wr_gnt=0, rd_gnt=0, win_ready=0, frame_done=0.

## Timing
- Grant cycle N: bram_addr, bram_en and bram_we (1 for write, 0 for read) are registered at N+1. Read data is valid from the BRAM at N+2. rd_row accompanies the address at N+1.
- Grant cycle with no transfer: bram_en=0 at N+1; bram_addr holds its last value.
- en low: outputs hold their values except bram_en=0; counters frozen; no grants.
- Reset mid-frame: all ring state discarded; next cycle is IDLE with outputs at reset values.
- Address arithmetic is ADDR_W wide, unsigned. slot*IMG_W uses localparam constants, not a runtime multiplier when IMG_W is a power of two.

## Configuration
- LBS_WR_PRIORITY_EN defined: fixed priority; the writer always wins contention. The round-robin pointer is not built.
- LBS_WR_PRIORITY_EN undefined: round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Package linebuf_pkg: state enum (IDLE/FILL/RUN/DRAIN/DONE) and localparam helpers for slot count and address width checks.
- Sub-module rr_arb2: two-requester arbiter with last-winner pointer. When LBS_WR_PRIORITY_EN is defined, it reduces to fixed priority.
- Counters, held tracking and address generation stay in linebuf_sched.

## Test plan
Bench parameters: IMG_W=8, IMG_H=6, LINES=4, WIN=3.
- Fill: wr_req=1 continuously, rd_req=0 → 24 grants; win_ready rises the cycle after the 24th write; writes continue to 32, then wr_gnt=0 (held=4).
- Contention: both requesting in RUN → grants alternate W,R,W,R; with LBS_WR_PRIORITY_EN defined → writer granted every cycle until held=LINES.
- Read addressing: first three read grants after fill → bram_addr 0, 8, 16 at N+1; fourth → 1. After 24 reads: rd_base=1, held decrements once.
- Ring wrap: writer line 4 → addresses 0..7 (slot 0), accepted only after row 0 retires.
- Frame end: after 6 lines written and 4 window rows read → frame_done pulses once; the next wr_req is granted to slot 0, line 0.
- Reset mid-RUN: assert reset with held=3 → next cycle all outputs 0, win_ready=0; refill required before any rd_gnt.
